// File: rtl/benes_cfg_loader_pkg.sv
// usr_fun: shared sizing, state and word types for the Benes configuration loader
package usr_fun;
  localparam int SIZE = 32;
  localparam int SWITCH_NUM = SIZE / 2;
  localparam int STAGE_NUM = 2 * $clog2(SIZE) - 1;
  typedef enum logic {LOAD, PENDING} cfg_state_t;
  typedef logic [SWITCH_NUM-1:0] stage_cfg_t;
endpackage

// File: rtl/benes_cfg_loader_bank.sv
// cfg_bank: per-stage register array with an indexed write port and a whole-bank load port
module cfg_bank #(
  parameter int W = 16,
  parameter int N = 9,
  parameter int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_wr_en,
  input  logic [IW-1:0] i_wr_idx,
  input  logic [W-1:0]  i_wr_data,
  input  logic          i_load_en,
  input  logic [W-1:0]  i_load_data [N],
  output logic [W-1:0]  o_data [N]
);
  logic [W-1:0] r_bank [N];
  // whole-bank load wins over a single-word write; all words clear on reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < N; i++) r_bank[i] <= '0;
    else if (i_load_en) r_bank <= i_load_data;
    else if (i_wr_en) r_bank[i_wr_idx] <= i_wr_data;
  assign o_data = r_bank;
endmodule

// File: rtl/benes_cfg_loader.sv
// benes_cfg_loader: assembles stage words in a shadow bank and commits them atomically to the active bank
module benes_cfg_loader
  import usr_fun::*;
#(
  parameter int SWITCH_NUM = usr_fun::SWITCH_NUM,
  parameter int STAGE_NUM = usr_fun::STAGE_NUM,
  parameter int IW = $clog2(STAGE_NUM)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_cfg_wr_valid,
  output logic                  o_cfg_wr_ready,
  input  logic [SWITCH_NUM-1:0] i_cfg_wr_data,
  input  logic                  i_cfg_abort,
  input  logic                  i_net_idle,
  output logic [SWITCH_NUM-1:0] o_switch_set [STAGE_NUM],
  output logic                  o_cfg_active_valid,
  output logic                  o_cfg_epoch,
  output logic                  o_cfg_commit,
  output logic [IW-1:0]         o_load_idx
);
  cfg_state_t r_state;
  logic [IW-1:0] r_idx;
  logic r_active_valid, r_epoch, r_commit;
  logic w_wr, w_commit;
  logic [SWITCH_NUM-1:0] w_shadow [STAGE_NUM];
  logic [SWITCH_NUM-1:0] w_active [STAGE_NUM];
  assign w_wr = r_state == LOAD && i_cfg_wr_valid && !i_cfg_abort;
  assign w_commit = r_state == PENDING && i_net_idle && !i_cfg_abort;
  cfg_bank #(.W(SWITCH_NUM), .N(STAGE_NUM), .IW(IW)) u_shadow (
    .clk(clk), .rst_n(rst_n), .i_wr_en(w_wr), .i_wr_idx(r_idx), .i_wr_data(i_cfg_wr_data),
    .i_load_en(1'b0), .i_load_data(w_shadow), .o_data(w_shadow)
  );
  cfg_bank #(.W(SWITCH_NUM), .N(STAGE_NUM), .IW(IW)) u_active (
    .clk(clk), .rst_n(rst_n), .i_wr_en(1'b0), .i_wr_idx('0), .i_wr_data('0),
    .i_load_en(w_commit), .i_load_data(w_shadow), .o_data(w_active)
  );
  // load/pending sequencing, index counter and commit bookkeeping; abort beats both beats and commits
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= LOAD;
      r_idx <= '0;
      r_active_valid <= 1'b0;
      r_epoch <= 1'b0;
      r_commit <= 1'b0;
    end else begin
      r_commit <= w_commit;
      if (w_commit) begin
        r_active_valid <= 1'b1;
        r_epoch <= ~r_epoch;
      end
      if (r_state == LOAD) begin
        if (i_cfg_abort) r_idx <= '0;
        else if (i_cfg_wr_valid) begin
          r_idx <= r_idx == IW'(STAGE_NUM - 1) ? '0 : r_idx + 1'b1;
          if (r_idx == IW'(STAGE_NUM - 1)) r_state <= PENDING;
        end
      end else if (i_cfg_abort || i_net_idle) r_state <= LOAD;
    end
  assign o_cfg_wr_ready = r_state == LOAD;
  assign o_switch_set = w_active;
  assign o_cfg_active_valid = r_active_valid;
  assign o_cfg_epoch = r_epoch;
  assign o_cfg_commit = r_commit;
  assign o_load_idx = r_idx;
endmodule

// File: tb/tb_benes_cfg_loader.sv
// tb_benes_cfg_loader: directed table, corner sequences and random traffic against a bank-level model
module tb_benes_cfg_loader;
  localparam int W = 16;
  localparam int N = 9;
  logic clk = 0, rst_n = 0;
  logic valid = 0, abort = 0, idle = 0;
  logic [W-1:0] data = '0;
  logic ready, av, ep, cm;
  logic [3:0] idx;
  logic [W-1:0] sw [N];
  int errors = 0, checks = 0;
  logic [W-1:0] m_sh [N];
  logic [W-1:0] m_act [N];
  int m_cnt;
  bit m_pend, m_ep, m_av, m_cm;
  typedef struct {bit v; logic [W-1:0] d; bit a; bit i; bit e_rdy; bit e_cm; int e_idx;} vec_t;
  vec_t tbl [11];

  benes_cfg_loader dut (
    .clk(clk), .rst_n(rst_n), .i_cfg_wr_valid(valid), .o_cfg_wr_ready(ready),
    .i_cfg_wr_data(data), .i_cfg_abort(abort), .i_net_idle(idle), .o_switch_set(sw),
    .o_cfg_active_valid(av), .o_cfg_epoch(ep), .o_cfg_commit(cm), .o_load_idx(idx)
  );
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [N*W-1:0] pack(input logic [W-1:0] a [N]);
    logic [N*W-1:0] r;
    for (int s = 0; s < N; s++) r[s*W +: W] = a[s];
    return r;
  endfunction

  task automatic m_reset();
    for (int s = 0; s < N; s++) begin m_sh[s] = '0; m_act[s] = '0; end
    m_cnt = 0; m_pend = 0; m_ep = 0; m_av = 0; m_cm = 0;
  endtask

  // a configuration is a list of N words; once all N have arrived it waits for an idle network
  task automatic m_edge();
    m_cm = 0;
    if (!m_pend) begin
      if (abort) m_cnt = 0;
      else if (valid) begin
        m_sh[m_cnt] = data;
        m_cnt++;
        if (m_cnt == N) begin m_cnt = 0; m_pend = 1; end
      end
    end else if (abort) m_pend = 0;
    else if (idle) begin
      m_act = m_sh; m_av = 1; m_ep = !m_ep; m_cm = 1; m_pend = 0;
    end
  endtask

  task automatic chk_all();
    chk("ready", ready, !m_pend);
    chk("active_valid", av, m_av);
    chk("epoch", ep, m_ep);
    chk("commit", cm, m_cm);
    chk("load_idx", idx, m_cnt);
    chk("switch_set", pack(sw), pack(m_act));
  endtask

  task automatic cyc(input bit v, input logic [W-1:0] d, input bit a, input bit i);
    valid = v; data = d; abort = a; idle = i;
    @(posedge clk);
    m_edge();
    #1;
    chk_all();
  endtask

  task automatic reset_now();
    rst_n = 0;
    #1;
    m_reset();
    chk_all();
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  initial begin
    m_reset();
    @(posedge clk);
    #1;
    chk_all();
    chk("reset switch_set", pack(sw), '0);
    rst_n = 1;
    // one-hot words back to back with the network idle, then the commit cycle and the one after
    for (int k = 0; k < N; k++)
      tbl[k] = '{1, W'(1) << k, 0, 1, k != N - 1, 0, (k + 1) % N};
    tbl[9] = '{0, '0, 0, 1, 1, 1, 0};
    tbl[10] = '{0, '0, 0, 1, 1, 0, 0};
    for (int r = 0; r < 11; r++) begin
      cyc(tbl[r].v, tbl[r].d, tbl[r].a, tbl[r].i);
      chk("tbl ready", ready, tbl[r].e_rdy);
      chk("tbl commit", cm, tbl[r].e_cm);
      chk("tbl idx", idx, tbl[r].e_idx);
    end
    for (int k = 0; k < N; k++) chk("onehot stage", sw[k], W'(1) << k);
    chk("epoch after first", ep, 1);
    // full load held pending by a busy network
    for (int k = 0; k < N; k++) cyc(1, W'($urandom), 0, 0);
    for (int c = 0; c < 20; c++) begin
      cyc($urandom_range(0, 1), W'($urandom), 0, 0);
      chk("busy ready low", ready, 0);
    end
    cyc(0, '0, 0, 1);
    chk("late commit", cm, 1);
    // abort mid-load drops the beat offered with it
    for (int k = 0; k < 5; k++) cyc(1, 16'h1111, 0, 0);
    cyc(1, 16'hDEAD, 1, 0);
    chk("abort idx", idx, 0);
    for (int k = 0; k < N; k++) cyc(1, 16'hA5A5, 0, 1);
    cyc(0, '0, 0, 1);
    for (int k = 0; k < N; k++) chk("a5 stage", sw[k], 16'hA5A5);
    // abort wins over commit while pending
    for (int k = 0; k < N; k++) cyc(1, W'($urandom), 0, 0);
    cyc(0, '0, 1, 1);
    chk("abort no commit", cm, 0);
    chk("abort epoch", ep, 1);
    chk("abort ready", ready, 1);
    // reset in the middle of a second configuration
    for (int k = 0; k < 4; k++) cyc(1, W'($urandom), 0, 1);
    reset_now();
    chk("rst active_valid", av, 0);
    chk("rst switch_set", pack(sw), '0);
    // random traffic with occasional aborts and resets
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 499) == 0) reset_now();
      else cyc($urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/benes_cfg_loader.md
# benes_cfg_loader

Configuration loader for the 32-port Beneš network: accepts switch-control words one stage per beat over a valid/ready write port and assembles them in a shadow bank. When a full configuration is in the shadow bank and the network is idle, it commits the whole bank to the active bank in one edge. The active bank drives the `switch_set` input of every `stage_module` instance. It sits directly upstream of the stage chain and is the only source of its switch settings.

## Interface
Parameters:
- `SWITCH_NUM`, default 16 (from `usr_fun`): switches per stage; width of one config word.
- `STAGE_NUM`, default 9 (from `usr_fun`): number of network stages; equals 2·log2(SIZE)−1.

Ports:
- `clk` input 1: single clock, all state on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `cfg_wr_valid` input 1: write beat offered.
- `cfg_wr_ready` output 1: loader can accept a beat.
- `cfg_wr_data` input SWITCH_NUM: switch word for the stage at the current load index.
- `cfg_abort` input 1: discard the partial or pending shadow configuration.
- `net_idle` input 1: the stage chain holds no frame in flight, so commit is allowed.
- `switch_set` output [SWITCH_NUM-1:0] × [0:STAGE_NUM-1]: active per-stage switch words.
- `cfg_active_valid` output 1: the active bank holds a committed configuration.
- `cfg_epoch` output 1: toggles on every commit.
- `cfg_commit` output 1: one-cycle pulse in the cycle after a commit edge.
- `load_idx` output $clog2(STAGE_NUM): next stage index to be written (debug/status).

## Operation
- State machine `LOAD` / `PENDING`; reset state is `LOAD`.
- `LOAD`:
  - `cfg_wr_ready` = 1.
  - Accept a beat when `cfg_wr_valid && cfg_wr_ready`: `shadow[load_idx] <= cfg_wr_data`, then `load_idx` increments.
  - On accepting the beat at index STAGE_NUM−1: `load_idx` wraps to 0 and the state goes to `PENDING`.
- `PENDING`:
  - `cfg_wr_ready` = 0.
  - If `net_idle` = 1, then on the next edge: `switch_set <= shadow` (all stages together), `cfg_active_valid <= 1`, `cfg_epoch` toggles, `cfg_commit <= 1`, state goes to `LOAD`.
- `cfg_abort` has priority over beat acceptance and over commit:
  - In `LOAD`: `load_idx <= 0`, the beat offered that cycle is not written.
  - In `PENDING`: return to `LOAD` with no commit.
  - The active bank and `cfg_active_valid` are never changed by an abort.
- The shadow contents are not cleared by an abort or a commit; they are overwritten by the next load.
- `switch_set` changes only on a commit edge, never partially.

## Timing
- Reset values: `switch_set` all 0 (every switch straight), `cfg_active_valid` 0, `cfg_epoch` 0, `cfg_commit` 0, `load_idx` 0, `cfg_wr_ready` 1. Shadow bank reset to 0.
- `cfg_wr_ready` is a registered-state decode with no combinational path from `cfg_wr_valid`.
- Load throughput: one beat per cycle. A full load takes STAGE_NUM accepted beats.
- Commit latency:
  - Last beat accepted at edge N puts the state in `PENDING` after N.
  - With `net_idle` high, the earliest commit is at edge N+1.
  - `net_idle` is not sampled in the same cycle as the last beat.
- `cfg_commit` is high for exactly the cycle following the commit edge. `cfg_wr_ready` returns to 1 in that same cycle.
- `net_idle` low holds `PENDING` indefinitely, with no timeout.
- Reset asserted mid-load or while `PENDING`: all registers return to their reset values immediately, and the partial configuration is lost.

## Structure
- `usr_fun` package:
  - add `STAGE_NUM` = 2*$clog2(SIZE)-1;
  - add `typedef enum logic {LOAD, PENDING} cfg_state_t`;
  - add `typedef logic [SWITCH_NUM-1:0] stage_cfg_t`.
- One natural sub-module, `cfg_bank`: a STAGE_NUM×SWITCH_NUM register array with an indexed write port and a whole-bank parallel-load port. It is instantiated twice, as shadow and active.
- The top-level owns the FSM, the index counter and the epoch/commit logic. `switch_set[s]` connects to the `switch_set` of stage instance s.

## Test plan
- Reset → `switch_set` all 0, `cfg_wr_ready`=1, `cfg_active_valid`=0, `cfg_epoch`=0.
- 9 back-to-back beats with data 16'h0001 << k (k=0..8), `net_idle`=1 → commit one edge after the last beat:
  - `switch_set[k]`=16'h0001<<k;
  - `cfg_commit` high for 1 cycle;
  - `cfg_epoch`=1.
- Full load with `net_idle`=0 for 20 cycles → `cfg_wr_ready`=0 and `switch_set` unchanged throughout; raise `net_idle` → commit on the next edge.
- 5 beats, then `cfg_abort` asserted together with a valid beat → `load_idx`=0 and that beat is dropped. A subsequent 9-beat load with 16'hA5A5 commits all stages = 16'hA5A5.
- `cfg_abort` and `net_idle` high in the same `PENDING` cycle → no commit, `cfg_epoch` unchanged, state returns to `LOAD`.
- Assert `rst_n` low after 4 beats of a second configuration → all outputs return to reset values, including `switch_set`=0 and `cfg_active_valid`=0.
